// File: rtl/if_id_if.sv
// Fetch-to-decode bundle: fetch outputs, EX/WB feedback, and the decoded ID-stage view.
interface if_id_if #(
  parameter int PC_WIDTH = 32
);
  logic [31:0]         ir_in;
  logic [PC_WIDTH-1:0] pc_in;
  logic                flush;
  logic                ex_mem_read;
  logic [4:0]          ex_rt;
  logic                wb_we;
  logic [4:0]          wb_addr;
  logic [31:0]         wb_data;

  logic                pc_en;
  logic                id_valid;
  logic [31:0]         id_ir;
  logic [PC_WIDTH-1:0] id_pc;
  logic [5:0]          opcode;
  logic [4:0]          rs;
  logic [4:0]          rt;
  logic [4:0]          rd;
  logic [5:0]          funct;
  logic [31:0]         imm_sext;
  logic [31:0]         rs_data;
  logic [31:0]         rt_data;
  logic                id_ex_bubble;

  modport master (
    output ir_in, pc_in, flush, ex_mem_read, ex_rt, wb_we, wb_addr, wb_data,
    input  pc_en, id_valid, id_ir, id_pc, opcode, rs, rt, rd, funct,
           imm_sext, rs_data, rt_data, id_ex_bubble
  );

  modport slave (
    input  ir_in, pc_in, flush, ex_mem_read, ex_rt, wb_we, wb_addr, wb_data,
    output pc_en, id_valid, id_ir, id_pc, opcode, rs, rt, rd, funct,
           imm_sext, rs_data, rt_data, id_ex_bubble
  );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with decode-side 32x32 register file and load-use hazard detection.
// Drives the fetch PC enable and requests an ID/EX bubble when the ID instruction cannot issue.
module if_id_stage #(
  parameter int          PC_WIDTH = 32,
  parameter logic [31:0] NOP_WORD = 32'h0
) (
  input logic     clk,
  input logic     rst_n,
  if_id_if.slave  bus
);

  logic [31:0]         r_ir;
  logic [PC_WIDTH-1:0] r_pc;
  logic                r_valid;
  logic [31:0]         r_regs [32];

  logic [5:0]  w_opcode;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic        w_uses_rt;
  logic        w_load_use;
  logic [31:0] w_rs_data;
  logic [31:0] w_rt_data;

  assign w_opcode = r_ir[31:26];
  assign w_rs     = r_ir[25:21];
  assign w_rt     = r_ir[20:16];

  // R-type, BEQ, BNE and SW read rt as a source; other I-types write it.
  assign w_uses_rt = (w_opcode == 6'h00) || (w_opcode == 6'h04) ||
                     (w_opcode == 6'h05) || (w_opcode == 6'h2B);

  assign w_load_use = bus.ex_mem_read && r_valid && (bus.ex_rt != 5'd0) &&
                      ((bus.ex_rt == w_rs) || (w_uses_rt && (bus.ex_rt == w_rt)));

  // Pipeline register: flush beats stall beats load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir    <= NOP_WORD;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (bus.flush) begin
      r_ir    <= NOP_WORD;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (!w_load_use) begin
      r_ir    <= bus.ir_in;
      r_pc    <= bus.pc_in;
      r_valid <= 1'b1;
    end
  end

  // NOTE: the register file is flop-based because every entry must clear on reset; a RAM macro could not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (bus.wb_we && (bus.wb_addr != 5'd0)) begin
      r_regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // NOTE: the WB write is forwarded combinationally so ID sees it in the same cycle it is written.
  always_comb begin
    w_rs_data = r_regs[w_rs];
    if (w_rs == 5'd0)                                 w_rs_data = '0;
    else if (bus.wb_we && (bus.wb_addr == w_rs))      w_rs_data = bus.wb_data;
  end

  always_comb begin
    w_rt_data = r_regs[w_rt];
    if (w_rt == 5'd0)                                 w_rt_data = '0;
    else if (bus.wb_we && (bus.wb_addr == w_rt))      w_rt_data = bus.wb_data;
  end

  // A flush lets fetch redirect even while a hazard is pending.
  assign bus.pc_en        = ~(w_load_use & ~bus.flush);
  assign bus.id_ex_bubble = ~r_valid | w_load_use;

  assign bus.id_valid = r_valid;
  assign bus.id_ir    = r_ir;
  assign bus.id_pc    = r_pc;
  assign bus.opcode   = w_opcode;
  assign bus.rs       = w_rs;
  assign bus.rt       = w_rt;
  assign bus.rd       = r_ir[15:11];
  assign bus.funct    = r_ir[5:0];
  assign bus.imm_sext = {{16{r_ir[15]}}, r_ir[15:0]};
  assign bus.rs_data  = w_rs_data;
  assign bus.rt_data  = w_rt_data;

endmodule

// File: tb/tb_if_id_stage.sv
// Randomized scoreboard bench for if_id_stage: a behavioural model predicts every cycle's outputs,
// a monitor compares them at the falling edge.
module tb_if_id_stage;

  logic clk;
  logic rst_n;

  if_id_if #(.PC_WIDTH(32)) bus ();

  if_id_stage #(.PC_WIDTH(32), .NOP_WORD(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pc_en;
    logic        id_valid;
    logic        bubble;
    logic [31:0] ir;
    logic [31:0] pc;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [31:0] imm;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state
  logic        m_valid;
  logic [31:0] m_ir;
  logic [31:0] m_pc;
  logic [31:0] m_regs [32];
  logic        last_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic we,
                                         input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  function automatic logic m_hazard(input logic exmr, input logic [4:0] exrt);
    logic [5:0] op;
    logic       uses_rt;
    op      = m_ir[31:26];
    uses_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
    return exmr && m_valid && (exrt != 5'd0) &&
           ((exrt == m_ir[25:21]) || (uses_rt && exrt == m_ir[20:16]));
  endfunction

  // One clock cycle: drive inputs, predict outputs, then advance the model across the edge.
  task automatic step(input logic rn, input logic fl, input logic exmr, input logic [4:0] exrt,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [31:0] ir, input logic [31:0] pc);
    exp_t e;
    logic lu;
    rst_n           = rn;
    bus.flush       = fl;
    bus.ex_mem_read = exmr;
    bus.ex_rt       = exrt;
    bus.wb_we       = we;
    bus.wb_addr     = wa;
    bus.wb_data     = wd;
    bus.ir_in       = ir;
    bus.pc_in       = pc;
    if (!rn) begin
      m_valid = 1'b0;
      m_ir    = 32'h0;
      m_pc    = 32'h0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    end
    lu         = m_hazard(exmr, exrt);
    e.pc_en    = !(lu && !fl);
    e.bubble   = !m_valid || lu;
    e.id_valid = m_valid;
    e.ir       = m_ir;
    e.pc       = m_pc;
    e.opcode   = m_ir[31:26];
    e.rs       = m_ir[25:21];
    e.rt       = m_ir[20:16];
    e.rd       = m_ir[15:11];
    e.funct    = m_ir[5:0];
    e.imm      = {{16{m_ir[15]}}, m_ir[15:0]};
    e.rs_data  = m_read(m_ir[25:21], we, wa, wd);
    e.rt_data  = m_read(m_ir[20:16], we, wa, wd);
    sb_q.push_back(e);
    last_stall = lu && !fl;
    @(posedge clk);
    if (rn) begin
      if (we && wa != 5'd0) m_regs[wa] = wd;
      if (fl) begin
        m_valid = 1'b0;
        m_ir    = 32'h0;
        m_pc    = 32'h0;
      end else if (!lu) begin
        m_valid = 1'b1;
        m_ir    = ir;
        m_pc    = pc;
      end
    end
    #1;
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("pc_en",        {31'h0, bus.pc_en},        {31'h0, e.pc_en});
        check("id_ex_bubble", {31'h0, bus.id_ex_bubble}, {31'h0, e.bubble});
        check("id_valid",     {31'h0, bus.id_valid},     {31'h0, e.id_valid});
        check("id_ir",        bus.id_ir,                 e.ir);
        check("id_pc",        bus.id_pc,                 e.pc);
        check("opcode",       {26'h0, bus.opcode},       {26'h0, e.opcode});
        check("rs",           {27'h0, bus.rs},           {27'h0, e.rs});
        check("rt",           {27'h0, bus.rt},           {27'h0, e.rt});
        check("rd",           {27'h0, bus.rd},           {27'h0, e.rd});
        check("funct",        {26'h0, bus.funct},        {26'h0, e.funct});
        check("imm_sext",     bus.imm_sext,              e.imm);
        check("rs_data",      bus.rs_data,               e.rs_data);
        check("rt_data",      bus.rt_data,               e.rt_data);
      end
    end
  end

  function automatic logic [31:0] rand_ir();
    logic [5:0] ops [6];
    ops = '{6'h00, 6'h04, 6'h05, 6'h2B, 6'h08, 6'h23};
    return {ops[$urandom_range(0, 5)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            16'($urandom)};
  endfunction

  initial begin
    logic        fl, exmr, we;
    logic [4:0]  exrt, wa;
    last_stall      = 1'b0;
    rst_n           = 1'b0;
    bus.flush       = 1'b0;
    bus.ex_mem_read = 1'b0;
    bus.ex_rt       = '0;
    bus.wb_we       = 1'b0;
    bus.wb_addr     = '0;
    bus.wb_data     = '0;
    bus.ir_in       = '0;
    bus.pc_in       = '0;
    @(posedge clk);
    #1;

    // Reset state
    step(0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 32'h0, 0);

    // Registers read zero for every rs after reset
    for (int i = 0; i < 32; i++)
      step(1, 0, 0, 0, 0, 0, 0, {6'h00, 5'(i), 5'(31 - i), 16'h1820}, 32'(i + 100));

    // Plain flow with one-cycle latency
    step(1, 0, 0, 0, 0, 0, 0, 32'h00221820, 5);
    step(1, 0, 0, 0, 0, 0, 0, 32'h00822820, 6);      // ADD rd5 = r4 + r2
    // Load-use on rs: stall one cycle, then load resumes
    step(1, 0, 1, 4, 0, 0, 0, 32'h20240010, 7);
    step(1, 0, 0, 0, 0, 0, 0, 32'h20240010, 7);      // ADDI rt4 = r1 + 16 enters ID
    // rt is a destination for ADDI: no stall
    step(1, 0, 1, 4, 0, 0, 0, 32'h00822820, 8);
    // Flush together with a pending load-use
    step(1, 1, 1, 4, 0, 0, 0, 32'h00E00000, 9);
    step(1, 0, 0, 0, 0, 0, 0, 32'h00E00000, 10);     // rs=7 enters ID
    // Write-through and persistence of r7, then an ignored write to r0
    step(1, 0, 0, 0, 1, 7, 32'hDEADBEEF, 32'h00E00000, 11);
    step(1, 0, 0, 0, 0, 0, 0, 32'h00000000, 12);
    step(1, 0, 0, 0, 1, 0, 32'h12345678, 32'h00000000, 13);
    step(1, 0, 0, 0, 0, 0, 0, 32'h00E00000, 14);
    step(1, 0, 0, 0, 0, 0, 0, 32'h00E00000, 15);

    // Randomized traffic with a mid-run reset
    for (int i = 0; i < 600; i++) begin
      fl   = ($urandom_range(0, 7) == 0);
      exmr = !last_stall && ($urandom_range(0, 2) == 0);
      exrt = ($urandom_range(0, 1) == 0) ? (($urandom_range(0, 1) == 0) ? m_ir[25:21] : m_ir[20:16])
                                         : 5'($urandom_range(0, 7));
      we   = ($urandom_range(0, 1) == 0);
      wa   = ($urandom_range(0, 2) == 0) ? m_ir[25:21] : 5'($urandom_range(0, 7));
      if (i >= 300 && i < 303)
        step(0, fl, exmr, exrt, 1'b0, wa, $urandom, rand_ir(), $urandom);
      else
        step(1, fl, exmr, exrt, we, wa, $urandom, rand_ir(), $urandom);
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
